// File: rtl/rattlesnake_fetch_aligner.sv
// Fetch aligner: turns the halfword-granular PC stream into one aligned instruction per beat.
// Optional macro RATTLESNAKE_FETCH_WORD_REUSE_EN serves the next instruction from the buffered word.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// S_IDLE    | no fetch in progress, waiting for fetch_start
// S_REQ_A   | read request for the word holding pc
// S_WAIT_A  | waiting for that word
// S_REQ_B   | read request for the word after the buffered word (straddle)
// S_WAIT_B  | waiting for the straddle's upper half
// S_REUSE   | present the buffered upper half without a memory read
// S_PRESENT | instr_valid_out pulse cycle
// S_HOLD    | instruction held until fetch_next
// S_DRAIN   | swallowing the ack of an abandoned read
module rattlesnake_fetch_aligner #(
    parameter int ADDR_BITS = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 sync_reset,
    input  logic                 fetch_start,
    input  logic [ADDR_BITS-1:0] fetch_pc,
    input  logic                 fetch_next,
    output logic                 mem_read_en,
    output logic [ADDR_BITS-3:0] mem_word_addr,
    input  logic                 mem_read_ack,
    input  logic [31:0]          mem_word_in,
    output logic                 instr_valid_out,
    output logic [31:0]          instr_out,
    output logic [ADDR_BITS-1:0] instr_pc_out
);

    localparam int WA = ADDR_BITS - 2;
    localparam logic [WA-1:0]        WORD_ONE  = 1;
    localparam logic [ADDR_BITS-1:0] HALF_MASK = {{(ADDR_BITS-1){1'b1}}, 1'b0};

    typedef enum logic [3:0] {
        S_IDLE,
        S_REQ_A,
        S_WAIT_A,
        S_REQ_B,
        S_WAIT_B,
        S_REUSE,
        S_PRESENT,
        S_HOLD,
        S_DRAIN
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_BITS-1:0]   pc_q, pc_d;
    logic [ADDR_BITS-1:0]   pc_next;
    logic [15:0]            buf_hi_q, buf_hi_d;
    logic [WA-1:0]          buf_addr_q, buf_addr_d;
    logic                   discard_q, discard_d;
    logic [31:0]            instr_q, instr_d;
    logic [ADDR_BITS-1:0]   instr_pc_q, instr_pc_d;
    logic                   valid_q, valid_d;
    logic                   rd_busy;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            pc_q       <= '0;
            buf_hi_q   <= '0;
            buf_addr_q <= '0;
            discard_q  <= 1'b0;
            instr_q    <= '0;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            buf_hi_q   <= buf_hi_d;
            buf_addr_q <= buf_addr_d;
            discard_q  <= discard_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
        end
    end

`ifdef RATTLESNAKE_FETCH_WORD_REUSE_EN
    logic buf_valid_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            buf_valid_q <= 1'b0;
        end else if (sync_reset || fetch_start) begin
            buf_valid_q <= 1'b0;
        end else if (mem_read_ack && (state_q == S_WAIT_A || state_q == S_WAIT_B)) begin
            buf_valid_q <= 1'b1;
        end
    end
`endif

    // A read is in flight (or will be) after this cycle unless its ack lands now.
    assign rd_busy = (state_q == S_REQ_A) || (state_q == S_REQ_B) ||
                     (((state_q == S_WAIT_A) || (state_q == S_WAIT_B) || discard_q) && !mem_read_ack);

    assign pc_next = pc_q + ((instr_q[1:0] == 2'b11) ? ADDR_BITS'(4) : ADDR_BITS'(2));

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        buf_hi_d   = buf_hi_q;
        buf_addr_d = buf_addr_q;
        discard_d  = discard_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        valid_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (discard_q && mem_read_ack) discard_d = 1'b0;
            end
            S_REQ_A: state_d = S_WAIT_A;
            S_WAIT_A: begin
                if (mem_read_ack) begin
                    buf_hi_d   = mem_word_in[31:16];
                    buf_addr_d = pc_q[ADDR_BITS-1:2];
                    if (!pc_q[1]) begin
                        instr_d    = (mem_word_in[1:0] == 2'b11) ? mem_word_in
                                                                 : {16'h0, mem_word_in[15:0]};
                        instr_pc_d = pc_q;
                        valid_d    = 1'b1;
                        state_d    = S_PRESENT;
                    end else if (mem_word_in[17:16] != 2'b11) begin
                        instr_d    = {16'h0, mem_word_in[31:16]};
                        instr_pc_d = pc_q;
                        valid_d    = 1'b1;
                        state_d    = S_PRESENT;
                    end else begin
                        state_d    = S_REQ_B;
                    end
                end
            end
            S_REQ_B: state_d = S_WAIT_B;
            S_WAIT_B: begin
                if (mem_read_ack) begin
                    instr_d    = {mem_word_in[15:0], buf_hi_q};
                    instr_pc_d = pc_q;
                    valid_d    = 1'b1;
                    buf_hi_d   = mem_word_in[31:16];
                    buf_addr_d = buf_addr_q + WORD_ONE;
                    state_d    = S_PRESENT;
                end
            end
            S_REUSE: begin
                instr_d    = {16'h0, buf_hi_q};
                instr_pc_d = pc_q;
                valid_d    = 1'b1;
                state_d    = S_PRESENT;
            end
            S_PRESENT: state_d = S_HOLD;
            S_HOLD: begin
                if (fetch_next) begin
                    pc_d    = pc_next;
                    state_d = S_REQ_A;
`ifdef RATTLESNAKE_FETCH_WORD_REUSE_EN
                    if (buf_valid_q && pc_next[1] && (pc_next[ADDR_BITS-1:2] == buf_addr_q)) begin
                        state_d = (buf_hi_q[1:0] == 2'b11) ? S_REQ_B : S_REUSE;
                    end
`endif
                end
            end
            S_DRAIN: begin
                if (mem_read_ack) begin
                    discard_d = 1'b0;
                    state_d   = S_REQ_A;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A restart abandons whatever was being assembled, including an ack landing now.
        if (fetch_start) begin
            pc_d    = fetch_pc & HALF_MASK;
            valid_d = 1'b0;
            if (rd_busy) begin
                state_d   = S_DRAIN;
                discard_d = 1'b1;
            end else begin
                state_d   = S_REQ_A;
                discard_d = 1'b0;
            end
        end

        if (sync_reset) begin
            state_d    = S_IDLE;
            pc_d       = '0;
            buf_hi_d   = '0;
            buf_addr_d = '0;
            instr_d    = '0;
            instr_pc_d = '0;
            valid_d    = 1'b0;
            discard_d  = rd_busy;
        end
    end

    always_comb begin
        mem_read_en   = 1'b0;
        mem_word_addr = '0;
        if (state_q == S_REQ_A) begin
            mem_read_en   = 1'b1;
            mem_word_addr = pc_q[ADDR_BITS-1:2];
        end else if (state_q == S_REQ_B) begin
            mem_read_en   = 1'b1;
            mem_word_addr = buf_addr_q + WORD_ONE;
        end
    end

    assign instr_valid_out = valid_q;
    assign instr_out       = instr_q;
    assign instr_pc_out    = instr_pc_q;

endmodule

// File: tb/tb_rattlesnake_fetch_aligner.sv
// Directed bench for rattlesnake_fetch_aligner: vector table plus hand sequences
// for restart, resets and the next-instruction path (with or without word reuse).
module tb_rattlesnake_fetch_aligner;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sync_reset = 1'b0;
    logic        fetch_start = 1'b0;
    logic [15:0] fetch_pc = '0;
    logic        fetch_next = 1'b0;
    logic        mem_read_en;
    logic [13:0] mem_word_addr;
    logic        mem_read_ack = 1'b0;
    logic [31:0] mem_word_in = '0;
    logic        instr_valid_out;
    logic [31:0] instr_out;
    logic [15:0] instr_pc_out;

    always #5 clk = ~clk;

    rattlesnake_fetch_aligner #(.ADDR_BITS(16)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .sync_reset     (sync_reset),
        .fetch_start    (fetch_start),
        .fetch_pc       (fetch_pc),
        .fetch_next     (fetch_next),
        .mem_read_en    (mem_read_en),
        .mem_word_addr  (mem_word_addr),
        .mem_read_ack   (mem_read_ack),
        .mem_word_in    (mem_word_in),
        .instr_valid_out(instr_valid_out),
        .instr_out      (instr_out),
        .instr_pc_out   (instr_pc_out)
    );

`ifdef RATTLESNAKE_FETCH_WORD_REUSE_EN
    localparam bit REUSE = 1'b1;
`else
    localparam bit REUSE = 1'b0;
`endif

    int nvec = 0;
    int nmis = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_rd(logic [13:0] a);
        case (a)
            14'h0000: return 32'h5566_1111;
            14'h0040: return 32'h00A0_0093;
            14'h0080: return 32'h0005_0505;
            14'h00C0: return 32'h0093_4501;
            14'h00C1: return 32'h1234_000A;
            14'h0100: return 32'hDEAD_BEEF;
            14'h0140: return 32'h0003_0001;
            14'h0141: return 32'h0000_ABCD;
            14'h0200: return 32'h0000_0013;
            14'h3FFF: return 32'h0003_4567;
            default:  return 32'h0000_0001;
        endcase
    endfunction

    // Memory responder: one outstanding read, ack after 'lat' cycles.
    int          lat = 1;
    bit          pend = 1'b0;
    int          cnt = 0;
    logic [13:0] pend_addr = '0;
    int          reads = 0;
    int          last_ack_cyc = -10;
    int          overlap_err = 0;
    int          valid_cnt = 0;
    logic [13:0] rlog[$];

    always @(negedge clk) begin
        mem_read_ack = 1'b0;
        if (pend) begin
            if (cnt <= 1) begin
                mem_read_ack = 1'b1;
                mem_word_in  = mem_rd(pend_addr);
                pend         = 1'b0;
                last_ack_cyc = cyc;
            end else begin
                cnt = cnt - 1;
            end
        end
        if (mem_read_en) begin
            if (pend) overlap_err = overlap_err + 1;
            pend      = 1'b1;
            cnt       = lat;
            pend_addr = mem_word_addr;
            reads     = reads + 1;
            rlog.push_back(mem_word_addr);
        end
        if (instr_valid_out) valid_cnt = valid_cnt + 1;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        nvec = nvec + 1;
        if (act !== exp) begin
            nmis = nmis + 1;
            $display("FAIL %s: actual %h, required %h", nm, act, exp);
        end
    endtask

    task automatic start(logic [15:0] pc);
        fetch_pc    = pc;
        fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
    endtask

    task automatic next_pulse(output int nc);
        fetch_next = 1'b1;
        nc         = cyc;
        step();
        fetch_next = 1'b0;
    endtask

    task automatic wait_valid(string nm, output logic [31:0] ins, output logic [15:0] ipc,
                              output int vc);
        bit got;
        got = 1'b0;
        ins = '0;
        ipc = '0;
        vc  = -1;
        for (int i = 0; i < 40 && !got; i++) begin
            step();
            if (instr_valid_out) begin
                got = 1'b1;
                vc  = cyc;
                ins = instr_out;
                ipc = instr_pc_out;
            end
        end
        chk({nm, " valid seen"}, 32'(got), 32'd1);
        if (got) begin
            step();
            chk({nm, " single pulse"}, 32'(instr_valid_out), 32'd0);
        end
    endtask

    // Fetch at spc, then advance once and check the second instruction.
    task automatic seq_next(string nm, logic [15:0] spc, int l, logic [31:0] ei, logic [15:0] ep,
                            int er, logic [13:0] ea);
        logic [31:0] ins;
        logic [15:0] ipc;
        int vc, nc, rb;
        lat = l;
        start(spc);
        wait_valid({nm, " first"}, ins, ipc, vc);
        rb = reads;
        next_pulse(nc);
        wait_valid({nm, " second"}, ins, ipc, vc);
        chk({nm, " instr"}, ins, ei);
        chk({nm, " pc"}, 32'(ipc), 32'(ep));
        chk({nm, " reads"}, 32'(reads - rb), 32'(er));
        if (reads > rb) chk({nm, " addr"}, 32'(rlog[rb]), 32'(ea));
        if (er == 0) chk({nm, " reuse timing"}, 32'(vc), 32'(nc + 2));
        else         chk({nm, " ack timing"}, 32'(vc), 32'(last_ack_cyc + 1));
    endtask

    typedef struct {
        logic [15:0] pc;
        int          l;
        logic [31:0] ins;
        logic [15:0] ipc;
        int          nrd;
        logic [13:0] a0;
        logic [13:0] a1;
    } vec_t;

    vec_t vt[6];

    initial begin
        logic [31:0] ins;
        logic [15:0] ipc;
        int vc, rb, vb, nc;

        vt[0] = '{16'h0100, 1, 32'h00A0_0093, 16'h0100, 1, 14'h0040, 14'h0000};
        vt[1] = '{16'h0200, 2, 32'h0000_0505, 16'h0200, 1, 14'h0080, 14'h0000};
        vt[2] = '{16'h0302, 1, 32'h000A_0093, 16'h0302, 2, 14'h00C0, 14'h00C1};
        vt[3] = '{16'hFFFE, 3, 32'h1111_0003, 16'hFFFE, 2, 14'h3FFF, 14'h0000};
        vt[4] = '{16'h0203, 1, 32'h0000_0005, 16'h0202, 1, 14'h0080, 14'h0000};
        vt[5] = '{16'h0102, 2, 32'h0000_00A0, 16'h0102, 1, 14'h0040, 14'h0000};

        step();
        step();
        chk("reset instr", instr_out, 32'h0);
        chk("reset pc", 32'(instr_pc_out), 32'h0);
        chk("reset ctl", 32'({instr_valid_out, mem_read_en, mem_word_addr}), 32'h0);
        reset_n = 1'b1;
        step();
        chk("post-reset ctl", 32'({instr_valid_out, mem_read_en, mem_word_addr}), 32'h0);

        for (int v = 0; v < 6; v++) begin
            rb  = reads;
            lat = vt[v].l;
            start(vt[v].pc);
            wait_valid($sformatf("vec%0d", v), ins, ipc, vc);
            chk($sformatf("vec%0d instr", v), ins, vt[v].ins);
            chk($sformatf("vec%0d pc", v), 32'(ipc), 32'(vt[v].ipc));
            chk($sformatf("vec%0d reads", v), 32'(reads - rb), 32'(vt[v].nrd));
            if (reads > rb) chk($sformatf("vec%0d addr0", v), 32'(rlog[rb]), 32'(vt[v].a0));
            if (vt[v].nrd == 2 && reads > rb + 1)
                chk($sformatf("vec%0d addr1", v), 32'(rlog[rb + 1]), 32'(vt[v].a1));
            chk($sformatf("vec%0d timing", v), 32'(vc), 32'(last_ack_cyc + 1));
        end

        seq_next("aligned next", 16'h0100, 1, 32'h0000_0001, 16'h0104, 1, 14'h0041);
        seq_next("compressed next", 16'h0200, 1, 32'h0000_0005, 16'h0202, REUSE ? 0 : 1, 14'h0080);
        seq_next("straddle next", 16'h0302, 1, 32'h0000_1234, 16'h0306, REUSE ? 0 : 1, 14'h00C1);
        seq_next("wrap next", 16'hFFFE, 2, 32'h0000_5566, 16'h0002, REUSE ? 0 : 1, 14'h0000);
        seq_next("reuse straddle", 16'h0500, 1, 32'hABCD_0003, 16'h0502, REUSE ? 1 : 2,
                 REUSE ? 14'h0141 : 14'h0140);

        // Restart while the first read is still outstanding.
        lat = 6;
        rb  = reads;
        vb  = valid_cnt;
        start(16'h0400);
        step();
        step();
        start(16'h0800);
        wait_valid("flush", ins, ipc, vc);
        chk("flush instr", ins, 32'h0000_0013);
        chk("flush pc", 32'(ipc), 32'h0800);
        chk("flush reads", 32'(reads - rb), 32'd2);
        if (reads > rb + 1) chk("flush addr", 32'(rlog[rb + 1]), 32'h0200);
        chk("flush pulses", 32'(valid_cnt - vb), 32'd1);

        // Synchronous reset with a read in flight, then an immediate restart.
        lat = 4;
        rb  = reads;
        start(16'h0100);
        for (int i = 0; i < 20 && reads < rb + 1; i++) step();
        sync_reset = 1'b1;
        step();
        sync_reset = 1'b0;
        chk("sync reset instr", instr_out, 32'h0);
        chk("sync reset pc", 32'(instr_pc_out), 32'h0);
        chk("sync reset ctl", 32'({instr_valid_out, mem_read_en, mem_word_addr}), 32'h0);
        start(16'h0200);
        wait_valid("sync restart", ins, ipc, vc);
        chk("sync restart instr", ins, 32'h0000_0505);
        chk("sync restart pc", 32'(ipc), 32'h0200);
        chk("sync restart reads", 32'(reads - rb), 32'd2);
        if (reads > rb + 1) chk("sync restart addr", 32'(rlog[rb + 1]), 32'h0080);

        // Asynchronous reset while waiting on the straddle's second word.
        lat = 5;
        rb  = reads;
        start(16'h0302);
        for (int i = 0; i < 30 && reads < rb + 2; i++) step();
        step();
        reset_n = 1'b0;
        #1;
        chk("async reset instr", instr_out, 32'h0);
        chk("async reset pc", 32'(instr_pc_out), 32'h0);
        chk("async reset ctl", 32'({instr_valid_out, mem_read_en, mem_word_addr}), 32'h0);
        step();
        reset_n = 1'b1;
        vb = valid_cnt;
        for (int i = 0; i < 15; i++) step();
        chk("async reset no pulse", 32'(valid_cnt - vb), 32'd0);
        for (int i = 0; i < 20 && pend; i++) step();

        // fetch_next outside HOLD is ignored; fetch_start beats fetch_next.
        lat = 3;
        start(16'h0100);
        step();
        next_pulse(nc);
        wait_valid("ignored next", ins, ipc, vc);
        chk("ignored next instr", ins, 32'h00A0_0093);
        chk("ignored next pc", 32'(ipc), 32'h0100);
        fetch_next = 1'b1;
        start(16'h0200);
        fetch_next = 1'b0;
        wait_valid("start priority", ins, ipc, vc);
        chk("start priority instr", ins, 32'h0000_0505);
        chk("start priority pc", 32'(ipc), 32'h0200);

        chk("no overlapping reads", 32'(overlap_err), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/rattlesnake_fetch_aligner.md
Name: rattlesnake_fetch_aligner

Overview:
- Fetch-side stage directly upstream of the instruction decompressor.
- Reads 32-bit words from instruction memory and re-aligns the halfword-granular PC stream into one instruction per output beat, including 32-bit instructions straddling a word boundary.
- Output bit [1:0] == 2'b11 marks a 32-bit instruction; any other value marks a 16-bit instruction in bits [15:0].
- Drives the decompressor's read-done, data and address-ack inputs.

Parameters:
- ADDR_BITS, 16, byte-address width of the PC and of instr_pc_out; the memory word address is ADDR_BITS-2 bits.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- sync_reset  in  1  synchronous reset, same effect as reset_n
- fetch_start  in  1  one-cycle pulse: restart fetching at fetch_pc (boot, branch, trap)
- fetch_pc  in  ADDR_BITS  restart byte address; bit0 ignored
- fetch_next  in  1  one-cycle pulse: consumer accepted the current instruction; advance
- mem_read_en  out  1  one-cycle read request pulse
- mem_word_addr  out  ADDR_BITS-2  word address of the request
- mem_read_ack  in  1  read data valid, variable latency >=1, at most one outstanding read
- mem_word_in  in  32  read data
- instr_valid_out  out  1  one-cycle pulse: new instruction presented (feeds mem_read_done)
- instr_out  out  32  aligned instruction; upper 16 bits are zero for compressed instructions
- instr_pc_out  out  ADDR_BITS  byte address of instr_out (feeds mem_addr_ack_in)

Behaviour:
- Reset (either reset): state IDLE; all outputs 0; pc 0; word buffer invalid; discard flag 0.
- States and transitions:
  - IDLE: wait for fetch_start.
  - REQ_A: pulse mem_read_en at word pc[ADDR_BITS-1:2] → WAIT_A.
  - WAIT_A: on mem_read_ack, latch word into buf_word/buf_addr, set buf valid.
    - pc[1]=0: present the full word.
    - pc[1]=1 and word[17:16]!=2'b11: present {16'h0, word[31:16]}.
    - pc[1]=1 and word[17:16]==2'b11: save upper half → REQ_B.
  - REQ_B: read word+1 → WAIT_B.
  - WAIT_B: on ack, present {new[15:0], saved_half}; buffer now holds the new word.
  - PRESENT: pulse instr_valid_out for exactly one cycle, with instr_out and instr_pc_out=pc registered in the same cycle → HOLD.
  - HOLD: outputs stable until fetch_next.
    - On fetch_next: pc += 4 if instr_out[1:0]==2'b11, else pc += 2.
    - Then REQ_A, or the reuse path (see Optional Feature).
- Latency: instr_valid_out asserts one cycle after the mem_read_ack that completes the instruction.
- fetch_start in any state has priority over fetch_next in the same cycle.
  - It sets pc=fetch_pc with bit0 forced to 0, invalidates the buffer, and goes to REQ_A the next cycle.
  - If a read is outstanding (WAIT_A/WAIT_B), set the discard flag and go to DRAIN. The next ack is dropped, then REQ_A.
  - fetch_start during DRAIN only updates pc.
- fetch_next outside HOLD is ignored.
- PC increment wraps modulo 2^ADDR_BITS. A word+1 request at the last word wraps to word 0.
- mem_read_en is never asserted while a read is outstanding.
- sync_reset mid-read: state returns to IDLE and the discard flag is set, so a late ack is ignored.

Optional Feature:
- Macro: RATTLESNAKE_FETCH_WORD_REUSE_EN.
- Defined: in HOLD after fetch_next, if the new pc's word == buf_addr and the buffer is valid:
  - new pc[1]=1 and buf upper half is a compressed instruction: present it with no memory read; instr_valid_out follows fetch_next by 2 cycles.
  - new pc[1]=1 and buf upper half starts a 32-bit instruction: save it and go directly to REQ_B.
- Not defined: every advance goes through REQ_A. The buffer is used only within REQ_B/WAIT_B.

Test Plan:
- Aligned 32-bit: fetch_start pc=0x0100, mem returns 0x00A00093 after 1 cycle → instr_out=0x00A00093, instr_pc_out=0x0100, one valid pulse; fetch_next → read at word 0x41.
- Two compressed: pc=0x0200, word 0x00050505 → first beat 0x00000505 @0x0200; fetch_next → 0x00000005 @0x0202. With REUSE_EN, no second mem_read_en; without it, word 0x80 is re-read.
- Straddling 32-bit: pc=0x0302, words 0x00934501 (0xC0) then 0x1234000A (0xC1) → instr_out=0x000A0093 @0x0302 after two reads; next pc=0x0306.
- Flush during wait: fetch_start pc=0x0400, then fetch_start pc=0x0800 before the ack → the first ack (0xDEADBEEF) is discarded; the next read is word 0x200; no valid pulse for the discarded data.
- Wrap: ADDR_BITS=16, pc=0xFFFE with upper half 0x0003 → second read at word 0x0000; instr_pc_out=0xFFFE; next pc=0x0002.
- Async reset asserted during WAIT_B → all outputs 0 immediately; no valid pulse after release until fetch_start.
